mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access controller between `exmem` and `memwb`. It turns the MEM-stage load/store controls into requests on a ready/valid memory port and returns load data as `data_from_memory_mem`. It drives `data_ready_mem`, the global pipeline stall, low until the current access has completed. Accesses are whole 32-bit words only, for integer and FPU loads/stores alike.

## Interface
- `ADDR_W`, 18: word-address width on the memory port.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `memread_mem`  in  1  load in MEM stage.
- `memwrite_mem`  in  1  store in MEM stage.
- `alu_result_mem`  in  32  byte address.
- `write_data_memory_mem`  in  32  store data.
- `alu_ready`  in  1  ALU not stalling; the pipeline advances on an edge where `data_ready_mem && alu_ready`.
- `data_from_memory_mem`  out  32  load result, held until the pipeline advances.
- `data_ready_mem`  out  1  MEM stage may advance.
- `mem_req_valid`  out  1  request valid.
- `mem_req_we`  out  1  1 = write.
- `mem_req_addr`  out  ADDR_W  word address, `alu_result_mem[ADDR_W+1:2]`.
- `mem_req_wdata`  out  32  write data.
- `mem_req_ready`  in  1  request accepted when valid && ready.
- `mem_resp_valid`  in  1  read data valid, one cycle per accepted read, in order.
- `mem_resp_rdata`  in  32  read data.

## Operation
- States: IDLE, WAIT_RESP, DONE.
- IDLE, no op: `data_ready_mem`=1, `mem_req_valid`=0.
- IDLE, op present: `mem_req_valid`=1, `data_ready_mem`=0.
  - Load accepted -> WAIT_RESP.
  - Store accepted -> DONE. Writes have no response.
- WAIT_RESP: `data_ready_mem`=0. On `mem_resp_valid`, capture `mem_resp_rdata` into the output register -> DONE.
- DONE: `data_ready_mem`=1, no new request. On an edge with `alu_ready`=1 -> IDLE. With `alu_ready`=0, stay in DONE, hold the data, and do not re-issue.
- Both `memread_mem` and `memwrite_mem` high: treated as a store.
- `mem_resp_valid` outside WAIT_RESP is ignored.
- Address bits [1:0] are ignored.

## Timing
- Reset: state IDLE, `data_from_memory_mem`=0, `mem_req_valid`=0, store buffer empty. `data_ready_mem`=1, since the MEM controls also reset to 0.
- `mem_req_*` and `data_ready_mem` are combinational from state and inputs. `data_from_memory_mem` is registered.
- Load, ready=1, response N cycles after acceptance: stall of N+1 cycles. Minimum 2 (N=1).
- Store, ready=1, buffer disabled: 1 stall cycle.
- `rst` asserted mid-access returns to IDLE next edge. Any in-flight response is dropped.

## Configuration
- `MEM_STORE_BUFFER_EN` defined: single-entry store buffer (address, data, valid).
  - Store in IDLE with buffer empty: `data_ready_mem`=1 with zero stall. The buffer captures the store on the advance edge.
  - Buffer full: drains with priority over new requests. The entry clears on acceptance.
  - Store with buffer full: stalls until the drain is accepted, then is buffered.
  - Load whose word address equals the buffered address: forwarded from the buffer, `data_ready_mem`=1 in the same cycle, no memory request.
  - Load to a different address with buffer full: waits for the drain, then issues normally.
  - Capture into a buffer being drained in the same cycle is legal.
- Not defined: no buffer; the behaviour in Operation applies.

## Structure
- Package `mem_pkg`: state enum typedef, default `ADDR_W`, word-address slice helper constants.
- Sub-module `store_buffer`, compiled only under `MEM_STORE_BUFFER_EN`. It holds valid/addr/data and provides capture, drain-accept and address-match outputs.

## Test plan
- Load 0x100, memory word 0x40 = 0xDEADBEEF, ready=1, response 1 cycle later -> 2 stall cycles, `mem_req_addr`=0x40, `data_from_memory_mem`=0xDEADBEEF.
- Load completes while `alu_ready`=0 for 3 cycles -> exactly one request, data held, `data_ready_mem`=1 throughout, IDLE after `alu_ready` rises.
- Store 0x12345678 to 0x200 with `mem_req_ready` low for 2 cycles -> `mem_req_valid`/`mem_req_we`=1 for 3 cycles, then DONE, one write to word 0x80.
- Under `MEM_STORE_BUFFER_EN`: store 0xCAFEF00D to 0x10, then a load from 0x10 with `mem_req_ready`=0 -> both zero-stall, load returns 0xCAFEF00D, no read request.
- Under `MEM_STORE_BUFFER_EN`: buffer full (0x10), load from 0x20 -> write 0x4 accepted first, then read 0x8.
- `rst` pulsed in WAIT_RESP, response arrives next cycle -> IDLE, response ignored, `data_from_memory_mem`=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-stage access unit.
// Optional feature macro: MEM_STORE_BUFFER_EN enables the single-entry store buffer.
package mem_pkg;

    // Access controller states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RESP = 2'd1,
        ST_DONE      = 2'd2
    } mem_state_t;

    // Default word-address width on the memory port
    localparam int MEM_ADDR_W = 18;

    // Byte-address bit where the word address starts (accesses are 32-bit words)
    localparam int WORD_LSB = 2;

endpackage

// File: rtl/mem_access_unit_if.sv
// Ready/valid memory port: request channel (unit -> memory) and read-response channel.
interface mem_access_unit_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
);
    logic              mem_req_valid;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [31:0]       mem_req_wdata;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/mem_access_unit_store_buffer.sv
// Single-entry store buffer (valid/address/data). Built only when
// MEM_STORE_BUFFER_EN is defined. A capture in the same cycle as a
// drain acceptance wins, so the entry stays valid with the new store.
`ifdef MEM_STORE_BUFFER_EN
module store_buffer
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [ADDR_W-1:0] capture_addr,
    input  logic [31:0]       capture_data,
    input  logic              drain_accept,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data,
    output logic              match
);
    logic              valid_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       data_reg;

    // Entry update: capture a new store, otherwise clear when the drain is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else if (capture) begin
            valid_reg <= 1'b1;
            addr_reg  <= capture_addr;
            data_reg  <= capture_data;
        end else if (drain_accept) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign addr  = addr_reg;
    assign data  = data_reg;
    assign match = valid_reg && (addr_reg == lookup_addr);
endmodule
`endif

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: turns MEM-stage load/store controls into
// ready/valid word requests, returns load data and drives the pipeline stall.
// Optional feature macro: MEM_STORE_BUFFER_EN (single-entry store buffer with
// load forwarding; stores then complete with zero stall).
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memread_mem,
    input  logic                  memwrite_mem,
    input  logic [31:0]           alu_result_mem,
    input  logic [31:0]           write_data_memory_mem,
    input  logic                  alu_ready,
    output logic [31:0]           data_from_memory_mem,
    output logic                  data_ready_mem,
    mem_access_unit_if.master     mem_port
);
    mem_state_t        state_reg;
    logic [31:0]       rdata_reg;
    logic [ADDR_W-1:0] word_addr;
    logic              is_store;
    logic              is_load;
    logic              unused_addr_bits;

    // Byte offset and bits above the memory port width carry no information
    assign word_addr        = alu_result_mem[ADDR_W+WORD_LSB-1:WORD_LSB];
    assign unused_addr_bits = ^{alu_result_mem[31:ADDR_W+WORD_LSB], alu_result_mem[WORD_LSB-1:0]};

    // Read+write together is a store
    assign is_store = memwrite_mem;
    assign is_load  = memread_mem & ~memwrite_mem;

    assign data_from_memory_mem = rdata_reg;

`ifdef MEM_STORE_BUFFER_EN
    logic              buf_valid;
    logic              buf_match;
    logic              buf_capture;
    logic              buf_drain;
    logic              fwd_hit;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_data;

    store_buffer #(.ADDR_W(ADDR_W)) u_store_buffer (
        .clk          (clk),
        .rst          (rst),
        .capture      (buf_capture),
        .capture_addr (word_addr),
        .capture_data (write_data_memory_mem),
        .drain_accept (buf_drain),
        .lookup_addr  (word_addr),
        .valid        (buf_valid),
        .addr         (buf_addr),
        .data         (buf_data),
        .match        (buf_match)
    );
`endif

    // Request channel and stall, decoded from state and current MEM controls
    always_comb begin
        mem_port.mem_req_valid = 1'b0;
        mem_port.mem_req_we    = 1'b0;
        mem_port.mem_req_addr  = word_addr;
        mem_port.mem_req_wdata = write_data_memory_mem;
        data_ready_mem         = 1'b0;
`ifdef MEM_STORE_BUFFER_EN
        buf_drain   = 1'b0;
        buf_capture = 1'b0;
        fwd_hit     = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
`ifdef MEM_STORE_BUFFER_EN
                if (buf_valid) begin
                    // A full buffer owns the port until its write is accepted
                    mem_port.mem_req_valid = 1'b1;
                    mem_port.mem_req_we    = 1'b1;
                    mem_port.mem_req_addr  = buf_addr;
                    mem_port.mem_req_wdata = buf_data;
                    buf_drain              = mem_port.mem_req_ready;
                    if (is_store) begin
                        data_ready_mem = mem_port.mem_req_ready;
                    end else if (is_load) begin
                        fwd_hit        = buf_match;
                        data_ready_mem = buf_match;
                    end else begin
                        data_ready_mem = 1'b1;
                    end
                end else if (is_load) begin
                    mem_port.mem_req_valid = 1'b1;
                end else begin
                    data_ready_mem = 1'b1;
                end
                buf_capture = is_store & data_ready_mem & alu_ready;
`else
                if (is_store || is_load) begin
                    mem_port.mem_req_valid = 1'b1;
                    mem_port.mem_req_we    = is_store;
                end else begin
                    data_ready_mem = 1'b1;
                end
`endif
            end
            ST_WAIT_RESP: data_ready_mem = 1'b0;
            ST_DONE:      data_ready_mem = 1'b1;
            default:      data_ready_mem = 1'b0;
        endcase
    end

    // Access sequencing and load-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            rdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
`ifdef MEM_STORE_BUFFER_EN
                    if (fwd_hit && alu_ready) begin
                        rdata_reg <= buf_data;
                    end else if (!buf_valid && is_load && mem_port.mem_req_ready) begin
                        state_reg <= ST_WAIT_RESP;
                    end
`else
                    if (mem_port.mem_req_valid && mem_port.mem_req_ready) begin
                        state_reg <= mem_port.mem_req_we ? ST_DONE : ST_WAIT_RESP;
                    end
`endif
                end
                ST_WAIT_RESP: begin
                    if (mem_port.mem_resp_valid) begin
                        rdata_reg <= mem_port.mem_resp_rdata;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (alu_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small memory responder.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int ADDR_W = MEM_ADDR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        memread_mem;
    logic        memwrite_mem;
    logic [31:0] alu_result_mem;
    logic [31:0] write_data_memory_mem;
    logic        alu_ready;
    logic [31:0] data_from_memory_mem;
    logic        data_ready_mem;

    int checks = 0;
    int errors = 0;

    // Responder state
    int          resp_lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    int          rd_count = 0;
    int          wr_count = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] mem_model [0:255];

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .memread_mem           (memread_mem),
        .memwrite_mem          (memwrite_mem),
        .alu_result_mem        (alu_result_mem),
        .write_data_memory_mem (write_data_memory_mem),
        .alu_ready             (alu_ready),
        .data_from_memory_mem  (data_from_memory_mem),
        .data_ready_mem        (data_ready_mem),
        .mem_port              (bus)
    );

    always #5 clk = ~clk;

    // Memory responder: logs accepted requests, answers reads after resp_lat cycles
    always @(posedge clk) begin
        bus.mem_resp_valid <= 1'b0;
        if (pend_cnt == 1) begin
            bus.mem_resp_valid <= 1'b1;
            bus.mem_resp_rdata <= pend_data;
        end
        if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            if (bus.mem_req_we) begin
                wr_count     <= wr_count + 1;
                last_wr_addr <= 32'(bus.mem_req_addr);
                last_wr_data <= bus.mem_req_wdata;
            end else begin
                rd_count     <= rd_count + 1;
                last_rd_addr <= 32'(bus.mem_req_addr);
                if (resp_lat <= 1) begin
                    bus.mem_resp_valid <= 1'b1;
                    bus.mem_resp_rdata <= mem_model[bus.mem_req_addr[7:0]];
                end else begin
                    pend_cnt  <= resp_lat - 1;
                    pend_data <= mem_model[bus.mem_req_addr[7:0]];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one op, count stall cycles until data_ready_mem, then advance
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, output int stalls);
        logic done;
        memread_mem           = rd;
        memwrite_mem          = wr;
        alu_result_mem        = addr;
        write_data_memory_mem = wd;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (data_ready_mem) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done) chk("op_timeout", 32'(stalls), 32'd0);
        @(posedge clk); #1;
        memread_mem  = 1'b0;
        memwrite_mem = 1'b0;
        $display("op rd=%0b wr=%0b addr=%h wdata=%h stalls=%0d data=%h",
                 rd, wr, addr, wd, stalls, data_from_memory_mem);
    endtask

    initial begin
        int  st;
        int  rd0;
        int  wr0;
        int  vcyc;
        logic seen;

        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        mem_model[8'h40] = 32'hDEADBEEF;
        mem_model[8'h41] = 32'h11223344;
        mem_model[8'h08] = 32'h0BADF00D;

        rst                   = 1'b1;
        memread_mem           = 1'b0;
        memwrite_mem          = 1'b0;
        alu_result_mem        = '0;
        write_data_memory_mem = '0;
        alu_ready             = 1'b1;
        bus.mem_req_ready     = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_data", data_from_memory_mem, 32'h0);
        chk("rst_ready", 32'(data_ready_mem), 32'd1);
        chk("rst_reqv", 32'(bus.mem_req_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset released");

        // Load 0x100, one-cycle response
        rd0 = rd_count;
        resp_lat = 1;
        run_op(1'b1, 1'b0, 32'h100, 32'h0, st);
        chk("ld1_stall", 32'(st), 32'd2);
        chk("ld1_data", data_from_memory_mem, 32'hDEADBEEF);
        chk("ld1_addr", last_rd_addr, 32'h40);
        chk("ld1_nrd", 32'(rd_count - rd0), 32'd1);

        // Load 0x20, three-cycle response
        resp_lat = 3;
        run_op(1'b1, 1'b0, 32'h20, 32'h0, st);
        chk("ld3_stall", 32'(st), 32'd4);
        chk("ld3_data", data_from_memory_mem, 32'h0BADF00D);
        resp_lat = 1;

        // Load completes while the ALU stalls
        rd0 = rd_count;
        alu_ready = 1'b0;
        memread_mem    = 1'b1;
        alu_result_mem = 32'h104;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (data_ready_mem) begin
                seen = 1'b1;
                break;
            end
        end
        chk("hold_reached", 32'(seen), 32'd1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("hold_ready", 32'(data_ready_mem), 32'd1);
            chk("hold_data", data_from_memory_mem, 32'h11223344);
            chk("hold_noreq", 32'(bus.mem_req_valid), 32'd0);
        end
        alu_ready = 1'b1;
        @(posedge clk); #1;
        memread_mem = 1'b0;
        $display("op held load addr=00000104 data=%h", data_from_memory_mem);
        @(negedge clk);
        chk("hold_nrd", 32'(rd_count - rd0), 32'd1);
        chk("hold_idle_ready", 32'(data_ready_mem), 32'd1);
        @(posedge clk); #1;

`ifndef MEM_STORE_BUFFER_EN
        // Store with memory not ready for two cycles
        wr0 = wr_count;
        bus.mem_req_ready     = 1'b0;
        memwrite_mem          = 1'b1;
        alu_result_mem        = 32'h200;
        write_data_memory_mem = 32'h12345678;
        vcyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.mem_req_valid && bus.mem_req_we) vcyc++;
            if (data_ready_mem) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (i == 1) bus.mem_req_ready = 1'b1;
        end
        chk("st_done", 32'(seen), 32'd1);
        chk("st_valid_cycles", 32'(vcyc), 32'd3);
        chk("st_done_noreq", 32'(bus.mem_req_valid), 32'd0);
        @(posedge clk); #1;
        memwrite_mem = 1'b0;
        $display("op store addr=00000200 wdata=12345678 valid_cycles=%0d", vcyc);
        chk("st_nwr", 32'(wr_count - wr0), 32'd1);
        chk("st_addr", last_wr_addr, 32'h80);
        chk("st_wdata", last_wr_data, 32'h12345678);

        // Read+write together acts as a store; byte offset ignored
        wr0 = wr_count;
        rd0 = rd_count;
        run_op(1'b1, 1'b1, 32'h303, 32'hA5A5A5A5, st);
        chk("rw_stall", 32'(st), 32'd1);
        chk("rw_nwr", 32'(wr_count - wr0), 32'd1);
        chk("rw_nrd", 32'(rd_count - rd0), 32'd0);
        chk("rw_addr", last_wr_addr, 32'hC0);
`else
        // Buffered store then forwarded load, memory never ready
        wr0 = wr_count;
        rd0 = rd_count;
        bus.mem_req_ready = 1'b0;
        run_op(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, st);
        chk("sb_st_stall", 32'(st), 32'd0);
        run_op(1'b1, 1'b0, 32'h10, 32'h0, st);
        chk("sb_fwd_stall", 32'(st), 32'd0);
        chk("sb_fwd_data", data_from_memory_mem, 32'hCAFEF00D);
        chk("sb_fwd_nrd", 32'(rd_count - rd0), 32'd0);
        chk("sb_fwd_nwr", 32'(wr_count - wr0), 32'd0);

        // Load to another word waits for the drain, then reads
        bus.mem_req_ready = 1'b1;
        run_op(1'b1, 1'b0, 32'h20, 32'h0, st);
        chk("sb_drain_stall", 32'(st), 32'd3);
        chk("sb_drain_addr", last_wr_addr, 32'h4);
        chk("sb_drain_data", last_wr_data, 32'hCAFEF00D);
        chk("sb_rd_addr", last_rd_addr, 32'h8);
        chk("sb_rd_data", data_from_memory_mem, 32'h0BADF00D);
`endif

        // Reset during WAIT_RESP; the late response must be dropped
        bus.mem_req_ready = 1'b1;
        resp_lat       = 2;
        memread_mem    = 1'b1;
        alu_result_mem = 32'h100;
        @(posedge clk); #1;
        rst         = 1'b1;
        memread_mem = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_data", data_from_memory_mem, 32'h0);
        chk("rstw_ready", 32'(data_ready_mem), 32'd1);
        chk("rstw_reqv", 32'(bus.mem_req_valid), 32'd0);
        @(negedge clk);
        chk("rstw_drop", data_from_memory_mem, 32'h0);
        chk("rstw_ready2", 32'(data_ready_mem), 32'd1);
        $display("op reset mid-load data=%h", data_from_memory_mem);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
